// File: rtl/dram_ring_read_ctrl.sv
// ---------------------------------------------------------------------------
// dram_ring_read_ctrl
//
// Read-side controller for the DRAM ring buffer. After en is seen and a
// start-up hold-off of STARTUP_CYCLES has elapsed, it reads words at rd_ptr
// until rd_ptr catches up with the writer's wr_ptr. Each word is forwarded to
// the BRAM readout stage. It honours BRAM back-pressure, re-issues DRAM reads
// that time out, and wraps rd_ptr at RING_DEPTH.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   start/continue reading (level)
//   wr_ptr     in   writer's next-write word address
//   rd_req     out  one-cycle DRAM read request pulse
//   rd_addr    out  DRAM word address (valid with rd_req, equals rd_ptr)
//   rd_val     in   DRAM read data valid strobe
//   rd_data    in   DRAM read data
//   bram_full  in   BRAM stage cannot accept a word
//   bram_we    out  BRAM write strobe, one cycle per word
//   bram_data  out  word for BRAM, valid with bram_we
//   rd_ptr     out  current read pointer
//   state      out  FSM state code (debug)
//   err_cnt    out  saturating DRAM read timeout count
//
// Build option:
//   RD_TIMEOUT_CNT_EN  when defined, err_cnt counts WAIT_VAL timeouts and
//                      saturates at 16'hFFFF; otherwise err_cnt is tied to 0.
// ---------------------------------------------------------------------------
module dram_ring_read_ctrl #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int RING_DEPTH     = 2**24,
  parameter int STARTUP_CYCLES = 129,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_val,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              bram_full,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_data,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [3:0]        state,
  output logic [15:0]       err_cnt
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WAIT_EN  = 4'd1,
    ST_STARTUP  = 4'd2,
    ST_CHECK    = 4'd3,
    ST_REQ      = 4'd4,
    ST_WAIT_VAL = 4'd5,
    ST_WRITE    = 4'd6
  } state_e;

  // One shared cycle counter serves both the start-up hold-off and the
  // read timeout, so it is sized for the larger of the two.
  localparam int CNT_MAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST     = ADDR_W'(RING_DEPTH - 1);

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [DATA_W-1:0] bram_data_q, bram_data_d;
  logic              rd_req_q,    rd_req_d;

  // Next-state, counter, pointer and capture logic of the read FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    bram_data_d = bram_data_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT_EN;
      end
      ST_WAIT_EN: begin
        if (en) begin
          state_d = ST_STARTUP;
          cnt_d   = '0;
        end else begin
          state_d = ST_WAIT_EN;
        end
      end
      ST_STARTUP: begin
        // en is deliberately not looked at during the hold-off.
        if (cnt_q == STARTUP_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_CHECK: begin
        // Dropping en keeps rd_ptr so reading resumes where it stopped.
        if (!en) begin
          state_d = ST_WAIT_EN;
        end else if (rd_ptr_q == wr_ptr) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT_VAL;
        cnt_d   = '0;
      end
      ST_WAIT_VAL: begin
        // Data arriving on the timeout cycle still counts as success.
        if (rd_val) begin
          bram_data_d = rd_data;
          state_d     = ST_WRITE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_WRITE: begin
        if (bram_full) begin
          state_d = ST_WRITE;
        end else begin
          if (rd_ptr_q == PTR_LAST) begin
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1'b1);
          end
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request strobe is registered: it is high exactly while the FSM sits in REQ.
  always_comb begin
    rd_req_d = 1'b0;
    if (state_d == ST_REQ) begin
      rd_req_d = 1'b1;
    end else begin
      rd_req_d = 1'b0;
    end
  end

  // FSM, counter, pointer, data and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      bram_data_q <= '0;
      rd_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      bram_data_q <= bram_data_d;
      rd_req_q    <= rd_req_d;
    end
  end

`ifdef RD_TIMEOUT_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        timeout_s;

  // A timeout is a WAIT_VAL cycle at the limit with no data returned.
  assign timeout_s = (state_q == ST_WAIT_VAL) && !rd_val && (cnt_q == TIMEOUT_LAST);

  // Saturating timeout counter.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (timeout_s && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Timeout counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

  // Strobes are masked by rst so nothing leaves the block while reset is
  // held, even in the cycle before the reset edge. bram_we must follow
  // bram_full in the same cycle, so it is decoded from the WRITE state.
  assign rd_req    = rd_req_q && !rst;
  assign bram_we   = (state_q == ST_WRITE) && !bram_full && !rst;
  assign rd_addr   = rd_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign bram_data = bram_data_q;
  assign state     = state_q;

endmodule

// File: doc/dram_ring_read_ctrl.md
Name: dram_ring_read_ctrl

Overview:
- Parametrised read-side controller for the DRAM ring buffer.
- After enable and a start-up hold-off, it reads words at rd_ptr until it catches up with the writer's pointer (wr_ptr), forwarding each word to the BRAM stage.
- Honours BRAM back-pressure, retries DRAM reads that time out, and wraps rd_ptr at RING_DEPTH.
- Sits between the DRAM read port and the BRAM readout buffer.

Parameters:
- ADDR_W, 24, width of DRAM word address and ring pointers.
- DATA_W, 32, DRAM read data width.
- RING_DEPTH, 2**24, ring size in words; rd_ptr wraps from RING_DEPTH-1 to 0; must be ≤ 2**ADDR_W.
- STARTUP_CYCLES, 129, hold-off cycles between en accepted and first read.
- TIMEOUT_CYCLES, 32, cycles to wait for rd_val before re-issuing the request; ≥ 2.

Ports:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, start/continue reading (level).
- wr_ptr, in, ADDR_W, writer's next-write word address.
- rd_req, out, 1, one-cycle DRAM read request pulse.
- rd_addr, out, ADDR_W, DRAM word address; valid while rd_req=1; equals rd_ptr.
- rd_val, in, 1, DRAM read data valid strobe.
- rd_data, in, DATA_W, DRAM read data; sampled when rd_val=1 in WAIT_VAL.
- bram_full, in, 1, BRAM stage cannot accept a word.
- bram_we, out, 1, BRAM write strobe; one cycle per word.
- bram_data, out, DATA_W, word for BRAM; valid while bram_we=1.
- rd_ptr, out, ADDR_W, current read pointer.
- state, out, 4, FSM state code, for debug.
- err_cnt, out, 16, timeout count (see Optional Feature).

Behaviour:
- Reset, synchronous, sampled on the clk edge:
  - state becomes IDLE; rd_ptr = 0; bram_data = 0; counters = 0; err_cnt = 0.
  - rd_req = 0 and bram_we = 0 from the first cycle rst is high.
  - Reset mid-transaction abandons it: no bram_we is issued, and a late rd_val is ignored.
- State codes: IDLE=0, WAIT_EN=1, STARTUP=2, CHECK=3, REQ=4, WAIT_VAL=5, WRITE=6.
- IDLE: always goes to WAIT_EN next cycle.
- WAIT_EN: stays until en=1; then goes to STARTUP with the cycle counter cleared.
- STARTUP:
  - Counter increments each cycle.
  - Leaves to CHECK on the cycle the counter equals STARTUP_CYCLES-1, i.e. exactly STARTUP_CYCLES cycles spent in STARTUP.
  - en is ignored here.
- CHECK, evaluated in priority order:
  - en=0: go to WAIT_EN; rd_ptr is retained, not reset.
  - rd_ptr==wr_ptr (ring empty): stay in CHECK.
  - Otherwise: go to REQ.
- REQ:
  - rd_req=1 and rd_addr=rd_ptr for this single cycle.
  - Go to WAIT_VAL with the timeout counter cleared.
- WAIT_VAL:
  - rd_val=1: capture rd_data into bram_data; go to WRITE.
  - No rd_val by the TIMEOUT_CYCLES-th cycle: go to REQ (same address); error event.
  - rd_val and the timeout in the same cycle: rd_val wins, no error.
  - rd_val outside WAIT_VAL is ignored.
- WRITE:
  - bram_full=1: stay in WRITE with bram_we=0 and bram_data held.
  - bram_full=0: bram_we=1 for this cycle; on the same edge rd_ptr advances (RING_DEPTH-1 → 0, else +1); go to CHECK.
- Throughput: minimum 4 cycles per word (CHECK, REQ, WAIT_VAL with rd_val=1, WRITE).
- Pointer comparison is exact on ADDR_W bits. Writer lapping the reader is not detectable and is out of scope.
- wr_ptr is used directly; the caller provides it synchronous to clk.

Optional Feature:
- Macro: RD_TIMEOUT_CNT_EN.
- Defined: err_cnt increments on each WAIT_VAL timeout, saturates at 16'hFFFF, and clears only on rst.
- Not defined: err_cnt is tied to 0 and no counter logic is built. Timeout and retry behaviour is identical in both builds.

Test Plan:
- Reset then en=1 with wr_ptr=0 → STARTUP lasts exactly STARTUP_CYCLES cycles, then state=3 holds indefinitely; rd_req never asserts.
- wr_ptr=3, DRAM model returns rd_val 2 cycles after rd_req with data=addr+0x100 → three bram_we pulses with data 0x100, 0x101, 0x102; rd_ptr ends at 3; state returns to 3.
- bram_full=1 for 10 cycles during the first word → state=6 is held for 10 cycles with bram_we=0 and bram_data stable; one bram_we after release; rd_ptr increments once.
- Model drops the first request at address 5 → rd_req re-asserts with rd_addr=5 exactly TIMEOUT_CYCLES cycles after entering WAIT_VAL. err_cnt=1 with RD_TIMEOUT_CNT_EN defined, 0 without.
- RING_DEPTH=16, rd_ptr=14, wr_ptr=1 → words read from addresses 14, 15, 0; rd_ptr ends at 1.
- rst pulsed while in WAIT_VAL, with rd_val arriving the next cycle → no bram_we; rd_ptr=0; state=0 then 1.
